// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 pipeline writeback slice.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Load kind carried down from decode.
    typedef enum logic [2:0] {
        LT_W  = 3'd0,
        LT_H  = 3'd1,
        LT_HU = 3'd2,
        LT_B  = 3'd3,
        LT_BU = 3'd4,
        LT_WL = 3'd5,
        LT_WR = 3'd6
    } load_type_t;

    // Writeback control states.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Big-endian load extraction and LWL/LWR merge; purely combinational.
module load_align
    import mips_pkg::*;
(
    input  logic [2:0]        load_type,
    input  logic [1:0]        byte_sel,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] rt_value,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and halfword; lane 0 is the most significant.
    always_comb begin
        sel_byte = 8'h00;
        unique case (byte_sel)
            2'd0: sel_byte = mem_word[31:24];
            2'd1: sel_byte = mem_word[23:16];
            2'd2: sel_byte = mem_word[15:8];
            2'd3: sel_byte = mem_word[7:0];
        endcase
        sel_half = byte_sel[1] ? mem_word[15:0] : mem_word[31:16];
    end

    // Extend or merge according to the load kind; unknown kinds act as LW.
    always_comb begin
        result = mem_word;
        case (load_type)
            LT_H:  result = {{16{sel_half[15]}}, sel_half};
            LT_HU: result = {16'h0000, sel_half};
            LT_B:  result = {{24{sel_byte[7]}}, sel_byte};
            LT_BU: result = {24'h000000, sel_byte};
            LT_WL: begin
                unique case (byte_sel)
                    2'd0: result = mem_word;
                    2'd1: result = {mem_word[23:0], rt_value[7:0]};
                    2'd2: result = {mem_word[15:0], rt_value[15:0]};
                    2'd3: result = {mem_word[7:0],  rt_value[23:0]};
                endcase
            end
            LT_WR: begin
                unique case (byte_sel)
                    2'd0: result = {rt_value[31:8],  mem_word[31:24]};
                    2'd1: result = {rt_value[31:16], mem_word[31:16]};
                    2'd2: result = {rt_value[31:24], mem_word[31:8]};
                    2'd3: result = mem_word;
                endcase
            end
            default: result = mem_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: registers results, waits on data-memory acks for loads,
// and drives the register-file write port / WB forwarding source.
module writeback_stage
    import mips_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              M_Valid,
    input  logic              M_Flush,
    input  logic              M_RegWrite,
    input  logic [REG_W-1:0]  M_WriteReg,
    input  logic [DATA_W-1:0] M_ALUResult,
    input  logic              M_MemRead,
    input  logic [2:0]        M_LoadType,
    input  logic [1:0]        M_ByteSel,
    input  logic [DATA_W-1:0] M_RtValue,
    input  logic              DataMem_Ack,
    input  logic [DATA_W-1:0] DataMem_Data,
    output logic              MemWait,
    output logic [REG_W-1:0]  WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              LoadPending,
    output logic [REG_W-1:0]  PendingReg
);

    // Handshake: in IDLE an instruction is taken on every edge where
    // M_Valid=1 and M_Flush=0. A load completes on the edge where
    // DataMem_Ack=1; until then MemWait=1 and upstream holds M_* stable.

    wb_state_t         state, state_next;
    logic              accept;
    logic              start_wait;
    logic              hold_reg_write;
    logic [REG_W-1:0]  hold_write_reg;
    logic [2:0]        hold_load_type;
    logic [1:0]        hold_byte_sel;
    logic [DATA_W-1:0] hold_rt_value;
    logic [2:0]        align_type;
    logic [1:0]        align_sel;
    logic [DATA_W-1:0] align_rt;
    logic [DATA_W-1:0] align_result;

    // Decode acceptance and whether a load must wait for its data.
    always_comb begin
        accept     = M_Valid && !M_Flush;
        start_wait = (state == IDLE) && accept && M_MemRead && !DataMem_Ack;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; WAIT_LOAD has no timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start_wait) state_next = WAIT_LOAD;
            WAIT_LOAD: if (DataMem_Ack) state_next = IDLE;
        endcase
    end

    // State-derived stall and pending-load outputs.
    always_comb begin
        MemWait     = 1'b0;
        LoadPending = 1'b0;
        PendingReg  = '0;
        if (state == WAIT_LOAD) begin
            MemWait     = 1'b1;
            LoadPending = 1'b1;
            PendingReg  = hold_write_reg;
        end
    end

    // Aligner sees the live MEM fields in IDLE and the held ones while waiting.
    always_comb begin
        align_type = (state == WAIT_LOAD) ? hold_load_type : M_LoadType;
        align_sel  = (state == WAIT_LOAD) ? hold_byte_sel  : M_ByteSel;
        align_rt   = (state == WAIT_LOAD) ? hold_rt_value  : M_RtValue;
    end

    load_align u_load_align (
        .load_type (align_type),
        .byte_sel  (align_sel),
        .mem_word  (DataMem_Data),
        .rt_value  (align_rt),
        .result    (align_result)
    );

    // Writeback registers and load hold registers; $zero writes are suppressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            WriteReg       <= '0;
            WriteData      <= '0;
            hold_reg_write <= 1'b0;
            hold_write_reg <= '0;
            hold_load_type <= '0;
            hold_byte_sel  <= '0;
            hold_rt_value  <= '0;
        end else if (state == IDLE) begin
            if (start_wait) begin
                RegWrite       <= 1'b0;
                hold_reg_write <= M_RegWrite;
                hold_write_reg <= M_WriteReg;
                hold_load_type <= M_LoadType;
                hold_byte_sel  <= M_ByteSel;
                hold_rt_value  <= M_RtValue;
            end else if (accept) begin
                RegWrite  <= M_RegWrite && (M_WriteReg != '0);
                WriteReg  <= M_WriteReg;
                WriteData <= M_MemRead ? align_result : M_ALUResult;
            end else begin
                RegWrite <= 1'b0;
            end
        end else begin
            if (DataMem_Ack) begin
                RegWrite  <= hold_reg_write && (hold_write_reg != '0);
                WriteReg  <= hold_write_reg;
                WriteData <= align_result;
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

endmodule
